result_drain: RTL
=================

RESULT_DRAIN -- requirements
Module: result_drain

Interface
REQ-001 SHALL have parameter PE_COUNT, default 4, number of 32-bit lanes per result-BRAM row.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, width of each lane.
REQ-003 SHALL have parameter INS_ADDR_WIDTH, default 11, result-BRAM read address width.
REQ-004 SHALL have parameter RD_LATENCY, default 2, result-BRAM read latency in cycles; legal values are 1 or greater.
REQ-005 SHALL have clk, input, 1 bit, the single clock; every register SHALL be clocked on its rising edge.
REQ-006 SHALL have rst, input, 1 bit, reset; rst SHALL be asynchronous and active-high.
REQ-007 SHALL have start, input, 1 bit, a drain request, sampled only in IDLE.
REQ-008 SHALL have row_count, input, INS_ADDR_WIDTH+1 bits, the number of rows to drain starting at address 0, latched on start.
REQ-009 SHALL have bram_r_r_addr, output, INS_ADDR_WIDTH bits, the result-BRAM read address.
REQ-010 SHALL have bram_r_r_data, input, PE_COUNT*DATA_WIDTH bits, the result row with lane 0 in the LSBs.
REQ-011 SHALL have m_tdata, output, DATA_WIDTH bits; m_tvalid, output, 1 bit; m_tready, input, 1 bit; m_tlast, output, 1 bit; together the lane stream.
REQ-012 SHALL have busy, output, 1 bit, high from start acceptance until done; and done, output, 1 bit, a one-cycle completion pulse.

Function
REQ-013 SHALL implement the FSM states IDLE, ADDR, WAIT, SEND and FIN.
- IDLE goes to ADDR on start with row_count>0.
- ADDR goes to WAIT.
- WAIT goes to SEND after RD_LATENCY cycles.
- SEND goes to ADDR after the last lane of a non-final row.
- SEND goes to FIN after the last lane of the final row.
- FIN goes to IDLE.
REQ-014 SHALL ignore start when not in IDLE; row_count SHALL be held internally, so later changes to the input have no effect.
REQ-015 SHALL, on start with row_count==0, go directly to FIN: done pulses on the next cycle, with no stream output and no BRAM read.
REQ-016 SHALL drive bram_r_r_addr with the current row index from ADDR onward and hold it stable through WAIT.
REQ-017 SHALL capture bram_r_r_data into a row buffer on the final WAIT cycle and SHALL NOT sample it at any other time, except as described in REQ-024.
REQ-018 SHALL, in SEND, present lane k of the buffered row on m_tdata with m_tvalid=1, starting at k=0.
- k SHALL advance only on a cycle where m_tvalid and m_tready are both 1.
- m_tdata and m_tlast SHALL stay stable while m_tvalid=1 and m_tready=0.
REQ-019 SHALL assert m_tlast only on lane PE_COUNT-1 of row row_count-1.
REQ-020 SHALL pass lane bits unmodified; no sign extension or arithmetic is applied.
REQ-021 SHALL raise the first m_tvalid exactly RD_LATENCY+2 cycles after the cycle in which start is sampled.
REQ-022 SHALL raise done for exactly one cycle in FIN; busy SHALL fall in the same cycle that FIN is left.
REQ-023 SHALL tolerate m_tready held low indefinitely, with no data loss and no change to the BRAM address.

Reset
REQ-024 SHALL, while rst=1, immediately force the following, including in the middle of a drain:
- state = IDLE;
- m_tvalid=0, m_tlast=0, m_tdata=0;
- bram_r_r_addr=0;
- busy=0, done=0;
- lane and row counters = 0.
A drain interrupted by reset SHALL NOT resume; a new start is required.

Configuration
REQ-025 SHALL, when macro RESULT_DRAIN_PREFETCH_EN is defined, overlap reads across rows:
- drive address r+1 on the first SEND cycle of row r;
- capture that row RD_LATENCY cycles later into a shadow buffer;
- move the shadow buffer to the active buffer on the last-lane handshake;
- present lane 0 of row r+1 on the next cycle, so the stream is gapless under continuous m_tready=1;
- the build SHALL fail with $error if PE_COUNT <= RD_LATENCY.
REQ-026 SHALL, without RESULT_DRAIN_PREFETCH_EN, present row r+1 lane 0 exactly RD_LATENCY+2 cycles after the last-lane handshake of row r, and SHALL have no shadow buffer.

Verification
REQ-027 SHALL cover a basic drain: BRAM rows 0..2 with lanes {10*r+k}, row_count=3, m_tready=1 -> exactly 12 beats 0,1,2,3,10,11,12,13,20,21,22,23; tlast only on 23; done pulses once.
REQ-028 SHALL cover backpressure: the same data with m_tready toggling 1,0,0,1 repeating -> the identical 12-beat sequence; tdata stable during every stall; BRAM address never skips.
REQ-029 SHALL cover zero rows: row_count=0 with start -> done on the next cycle, m_tvalid never 1, bram_r_r_addr stays 0.
REQ-030 SHALL cover latency: start in cycle 0 -> m_tvalid first high in cycle 4 (RD_LATENCY=2).
- With prefetch: row 1 lane 0 in the cycle after the row 0 lane 3 handshake.
- Without prefetch: 4 cycles after that handshake.
REQ-031 SHALL cover reset mid-drain: rst pulsed after beat 5 of 12 -> outputs zero within the same cycle; a new start with row_count=1 -> beats 0,1,2,3 with tlast on 3.
REQ-032 SHALL cover start while busy: start reasserted during SEND -> ignored; the beat count still equals 4*row_count; a single done pulse.

Source files
------------

// File: rtl/result_drain.sv
// Drains result-BRAM rows onto a lane-serial AXI-Stream, one DATA_WIDTH lane per beat.
// Optional RESULT_DRAIN_PREFETCH_EN overlaps the next row read with the current row's beats.
module result_drain #(
    parameter int PE_COUNT       = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int INS_ADDR_WIDTH = 11,
    parameter int RD_LATENCY     = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [INS_ADDR_WIDTH:0]        row_count,
    output logic [INS_ADDR_WIDTH-1:0]      bram_r_r_addr,
    input  logic [PE_COUNT*DATA_WIDTH-1:0] bram_r_r_data,
    output logic [DATA_WIDTH-1:0]          m_tdata,
    output logic                           m_tvalid,
    input  logic                           m_tready,
    output logic                           m_tlast,
    output logic                           busy,
    output logic                           done
);

    localparam int ROW_W  = INS_ADDR_WIDTH + 1;
    localparam int LANE_W = (PE_COUNT > 1) ? $clog2(PE_COUNT) : 1;
    localparam int LAT_W  = $clog2(RD_LATENCY + 1);
    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(PE_COUNT - 1);
    localparam logic [LAT_W-1:0]  LAT_INIT  = LAT_W'(RD_LATENCY - 1);

`ifdef RESULT_DRAIN_PREFETCH_EN
    localparam bit PREFETCH = 1'b1;
    if (PE_COUNT <= RD_LATENCY) begin : g_bad_prefetch_cfg
        $error("result_drain: prefetch requires PE_COUNT > RD_LATENCY");
    end
`else
    localparam bit PREFETCH = 1'b0;
`endif

    if (RD_LATENCY < 1) begin : g_bad_latency_cfg
        $error("result_drain: RD_LATENCY must be at least 1");
    end

    typedef enum logic [2:0] {IDLE, ADDR, WAIT, SEND, FIN} state_t;
    typedef logic [PE_COUNT-1:0][DATA_WIDTH-1:0] row_t;

    state_t                    state_q, state_d;
    logic [ROW_W-1:0]          rows_q;
    logic [ROW_W-1:0]          row_idx;
    logic [ROW_W-1:0]          row_next;
    logic [ROW_W-1:0]          rows_m1;
    logic [LANE_W-1:0]         lane_idx;
    logic [LAT_W-1:0]          wait_cnt;
    logic [INS_ADDR_WIDTH-1:0] addr_q;
    row_t                      row_buf;
    logic                      hs;
    logic                      lane_end;
    logic                      row_last;
    logic                      wait_end;

    assign row_next = row_idx + ROW_W'(1);
    assign rows_m1  = rows_q - ROW_W'(1);
    assign row_last = (row_idx == rows_m1);
    assign wait_end = (state_q == WAIT) && (wait_cnt == '0);
    assign hs       = m_tvalid && m_tready;
    assign lane_end = hs && (lane_idx == LANE_LAST);

    assign m_tvalid      = (state_q == SEND);
    assign m_tdata       = m_tvalid ? row_buf[lane_idx] : '0;
    assign m_tlast       = m_tvalid && (lane_idx == LANE_LAST) && row_last;
    assign busy          = (state_q != IDLE);
    assign done          = (state_q == FIN);
    assign bram_r_r_addr = addr_q;

`ifdef RESULT_DRAIN_PREFETCH_EN
    logic                      pf_issue;
    logic                      pf_pending;
    logic                      capture_now;
    logic [LAT_W-1:0]          pf_cnt;
    logic [INS_ADDR_WIDTH-1:0] pf_addr;
    logic [INS_ADDR_WIDTH-1:0] row_next2;
    row_t                      shadow_buf;

    // Issue the next row's read as each row starts streaming, unless it is the final row.
    assign row_next2   = row_idx[INS_ADDR_WIDTH-1:0] + INS_ADDR_WIDTH'(2);
    assign pf_issue    = (wait_end && !row_last) || (lane_end && !row_last && (row_next != rows_m1));
    assign pf_addr     = (state_q == WAIT) ? row_next[INS_ADDR_WIDTH-1:0] : row_next2;
    assign capture_now = pf_pending && (pf_cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pf_pending <= 1'b0;
            pf_cnt     <= '0;
        end else if (pf_issue) begin
            pf_pending <= 1'b1;
            pf_cnt     <= LAT_W'(RD_LATENCY);
        end else if (pf_pending) begin
            if (pf_cnt != '0) pf_cnt <= pf_cnt - LAT_W'(1);
            else              pf_pending <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (capture_now) shadow_buf <= bram_r_r_data;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start) state_d = (row_count == '0) ? FIN : ADDR;
            ADDR: state_d = WAIT;
            WAIT: if (wait_cnt == '0) state_d = SEND;
            SEND: if (lane_end) state_d = row_last ? FIN : (PREFETCH ? SEND : ADDR);
            FIN:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rows_q   <= '0;
            row_idx  <= '0;
            lane_idx <= '0;
            wait_cnt <= '0;
            addr_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: if (start) begin
                    rows_q   <= row_count;
                    row_idx  <= '0;
                    lane_idx <= '0;
                    addr_q   <= '0;
                end
                ADDR: wait_cnt <= LAT_INIT;
                WAIT: if (wait_cnt != '0) wait_cnt <= wait_cnt - LAT_W'(1);
                SEND: if (hs) begin
                    lane_idx <= lane_end ? '0 : lane_idx + LANE_W'(1);
                    if (lane_end && !row_last) begin
                        row_idx <= row_next;
                        if (!PREFETCH) addr_q <= row_next[INS_ADDR_WIDTH-1:0];
                    end
                end
                FIN: begin
                    row_idx <= '0;
                    addr_q  <= '0;
                end
                default: ;
            endcase
`ifdef RESULT_DRAIN_PREFETCH_EN
            if (pf_issue) addr_q <= pf_addr;
`endif
        end
    end

    // NOTE: the row buffer carries no reset; m_tdata is gated by state so stale contents never leak.
    always_ff @(posedge clk) begin
        if (wait_end) begin
            row_buf <= bram_r_r_data;
        end
`ifdef RESULT_DRAIN_PREFETCH_EN
        else if (lane_end && !row_last) begin
            // Bypass covers the shadow read landing on the very cycle of the last-lane handshake.
            row_buf <= capture_now ? bram_r_r_data : shadow_buf;
        end
`endif
    end

endmodule
